pipeline_hazard_controller: RTL and testbench

Sequencing controller for the IF/ID and ID/EX pipeline registers. It produces the `stall`, `flush` and `pc_en` controls each cycle. Its decisions come from three sources: load-use hazards detected between ID and EX, taken branches resolved in EX, and data-memory wait requests from MEM. It sits beside the pipeline register bank and the PC register, and also keeps saturating performance counters for stall cycles and branch flushes.

---
 rtl/pipeline_pkg.sv | 12 +
 rtl/pipeline_hazard_controller_sat_counter.sv | 22 ++
 rtl/pipeline_hazard_controller.sv | 133 +++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline hazard controller: FSM states and register index width.
package pipeline_pkg;

    localparam int REG_IDX_W = 4;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    // Clear wins over increment; increment is suppressed once all-ones is reached.
    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush/PC-enable sequencing for the IF/ID and ID/EX registers, with
// saturating counters for stall cycles and taken-branch flushes.
//
// state    | meaning
// ---------+----------------------------------------------------------
// RUN      | normal issue; branch, memory wait and load-use are decided here
// FLUSH    | remaining flush cycles of a taken branch (rem counts down)
// MEM_WAIT | holding for data memory; exits on the first non-busy cycle
// (3)      | illegal encoding, handled as RUN and steered back to RUN
module pipeline_hazard_controller
    import pipeline_pkg::*;
#(
    parameter int BRANCH_PENALTY = 1,
    parameter int CNT_W          = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_mem_read_en,
    input  logic                 ex_branch_taken,
    input  logic                 mem_busy,
    output logic                 stall,
    output logic                 flush,
    output logic                 pc_en,
    output logic [1:0]           state,
    output logic [CNT_W-1:0]     stall_cycles,
    output logic [CNT_W-1:0]     flush_events
);

    localparam logic [2:0] REM_START = 3'(BRANCH_PENALTY - 1);

    state_t     state_q;
    state_t     state_d;
    logic [2:0] rem_q;
    logic [2:0] rem_d;
    logic       lu;
    logic       branch_start;

    assign lu = ex_mem_read_en &
                ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

    assign state = state_q;

    // Mealy decision: controls and next state from the current state and live inputs.
    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        stall        = 1'b0;
        flush        = 1'b0;
        pc_en        = 1'b1;
        branch_start = 1'b0;

        if (!rst_n) begin
            stall   = 1'b0;
            flush   = 1'b1;
            pc_en   = 1'b0;
            state_d = ST_RUN;
            rem_d   = 3'd0;
        end else begin
            case (state_q)
                ST_FLUSH: begin
                    // EX holds a bubble here, so branch/busy/load-use are not looked at.
                    flush = 1'b1;
                    pc_en = 1'b1;
                    rem_d = (rem_q == 3'd0) ? 3'd0 : rem_q - 3'd1;
                    if (rem_q <= 3'd1) begin
                        state_d = ST_RUN;
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_busy) begin
                        stall = 1'b1;
                        pc_en = 1'b0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    // RUN, and the illegal encoding which recovers to RUN.
                    state_d = ST_RUN;
                    if (ex_branch_taken) begin
                        flush        = 1'b1;
                        pc_en        = 1'b1;
                        branch_start = 1'b1;
                        if (BRANCH_PENALTY > 1) begin
                            state_d = ST_FLUSH;
                            rem_d   = REM_START;
                        end
                    end else if (mem_busy) begin
                        stall   = 1'b1;
                        pc_en   = 1'b0;
                        state_d = ST_MEM_WAIT;
                    end else if (lu) begin
                        // One bubble into ID/EX while IF/ID holds.
                        stall = 1'b1;
                        flush = 1'b1;
                        pc_en = 1'b0;
                    end
                end
            endcase
        end
    end

    // State and flush-remaining registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            rem_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clr   (~rst_n),
        .inc   (stall),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clr   (~rst_n),
        .inc   (branch_start),
        .count (flush_events)
    );

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: a directed vector table, hand sequences
// for counters/saturation, and randomized stimulus against a behavioural model.
// Two instances share stimulus: penalty 3 / 16-bit counters and penalty 1 / 4-bit counters.
module tb_pipeline_hazard_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_mem_read_en, ex_branch_taken, mem_busy;

    logic        d_stall, d_flush, d_pc_en;
    logic [1:0]  d_state;
    logic [15:0] d_stall_cycles, d_flush_events;

    logic        s_stall, s_flush, s_pc_en;
    logic [1:0]  s_state;
    logic [3:0]  s_stall_cycles, s_flush_events;

    int checks = 0;
    int errors = 0;

    // Model state per instance: 0 = penalty 3 / 16-bit, 1 = penalty 1 / 4-bit.
    int m_flush_left [2];
    bit m_wait       [2];
    int m_stalls     [2];
    int m_flushes    [2];
    int pen          [2] = '{3, 1};
    int cmax         [2] = '{65535, 15};

    always #5 clk = ~clk;

    pipeline_hazard_controller #(.BRANCH_PENALTY(3), .CNT_W(16)) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .ex_rd           (ex_rd),
        .ex_mem_read_en  (ex_mem_read_en),
        .ex_branch_taken (ex_branch_taken),
        .mem_busy        (mem_busy),
        .stall           (d_stall),
        .flush           (d_flush),
        .pc_en           (d_pc_en),
        .state           (d_state),
        .stall_cycles    (d_stall_cycles),
        .flush_events    (d_flush_events)
    );

    pipeline_hazard_controller #(.BRANCH_PENALTY(1), .CNT_W(4)) u_sat (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .ex_rd           (ex_rd),
        .ex_mem_read_en  (ex_mem_read_en),
        .ex_branch_taken (ex_branch_taken),
        .mem_busy        (mem_busy),
        .stall           (s_stall),
        .flush           (s_flush),
        .pc_en           (s_pc_en),
        .state           (s_state),
        .stall_cycles    (s_stall_cycles),
        .flush_events    (s_flush_events)
    );

    typedef struct {
        logic       rn;
        logic [3:0] rs1;
        logic [3:0] rs2;
        logic       u1;
        logic       u2;
        logic [3:0] rd;
        logic       ld;
        logic       br;
        logic       busy;
        logic       es;
        logic       ef;
        logic       ep;
        logic [1:0] est;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rn, logic [3:0] rs1, logic [3:0] rs2, logic u1, logic u2,
                                logic [3:0] rd, logic ld, logic br, logic busy,
                                logic es, logic ef, logic ep, logic [1:0] est);
        vec_t v;
        v.rn = rn; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.rd = rd;
        v.ld = ld; v.br = br; v.busy = busy; v.es = es; v.ef = ef; v.ep = ep; v.est = est;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_in(input logic rn, input logic [3:0] rs1, input logic [3:0] rs2,
                          input logic u1, input logic u2, input logic [3:0] rd,
                          input logic ld, input logic br, input logic busy);
        rst_n = rn; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        ex_rd = rd; ex_mem_read_en = ld; ex_branch_taken = br; mem_busy = busy;
    endtask

    task automatic nop();
        set_in(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic busy_in();
        set_in(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic reset_in();
        set_in(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic int sat_inc(int v, int mx);
        return (v >= mx) ? mx : v + 1;
    endfunction

    // Behavioural reference: remaining flush cycles, a waiting flag, and plain counts.
    task automatic model_step(input int i, output logic es, output logic ef,
                              output logic ep, output int est);
        bit lu;
        lu = ex_mem_read_en && ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        est = (m_flush_left[i] > 0) ? 1 : (m_wait[i] ? 2 : 0);
        if (!rst_n) begin
            es = 0; ef = 1; ep = 0;
            m_flush_left[i] = 0; m_wait[i] = 0; m_stalls[i] = 0; m_flushes[i] = 0;
        end else begin
            if (m_flush_left[i] > 0) begin
                es = 0; ef = 1; ep = 1;
                m_flush_left[i]--;
            end else if (m_wait[i]) begin
                if (mem_busy) begin
                    es = 1; ef = 0; ep = 0;
                end else begin
                    es = 0; ef = 0; ep = 1;
                    m_wait[i] = 0;
                end
            end else if (ex_branch_taken) begin
                es = 0; ef = 1; ep = 1;
                m_flush_left[i] = pen[i] - 1;
                m_flushes[i] = sat_inc(m_flushes[i], cmax[i]);
            end else if (mem_busy) begin
                es = 1; ef = 0; ep = 0;
                m_wait[i] = 1;
            end else if (lu) begin
                es = 1; ef = 1; ep = 0;
            end else begin
                es = 0; ef = 0; ep = 1;
            end
            if (es) m_stalls[i] = sat_inc(m_stalls[i], cmax[i]);
        end
    endtask

    // Sample at the falling edge: counters first (they reflect past edges), then controls.
    task automatic eval_cycle();
        logic es, ef, ep;
        int   est;
        @(negedge clk);
        chk("dut.stall_cycles", int'(d_stall_cycles), m_stalls[0]);
        chk("dut.flush_events", int'(d_flush_events), m_flushes[0]);
        chk("sat.stall_cycles", int'(s_stall_cycles), m_stalls[1]);
        chk("sat.flush_events", int'(s_flush_events), m_flushes[1]);
        model_step(0, es, ef, ep, est);
        chk("dut.stall", int'(d_stall), int'(es));
        chk("dut.flush", int'(d_flush), int'(ef));
        chk("dut.pc_en", int'(d_pc_en), int'(ep));
        chk("dut.state", int'(d_state), est);
        model_step(1, es, ef, ep, est);
        chk("sat.stall", int'(s_stall), int'(es));
        chk("sat.flush", int'(s_flush), int'(ef));
        chk("sat.pc_en", int'(s_pc_en), int'(ep));
        chk("sat.state", int'(s_state), est);
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        eval_cycle();
        next_edge();
    endtask

    initial begin
        int nflush;
        int nstall;

        // Directed vectors for the penalty-3 instance, run in order from reset.
        //            rn rs1 rs2 u1 u2 rd ld br busy   es ef ep st
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1, 1, 1,   0, 1, 0, 0)); // reset forces 0/1/0
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0)); // idle
        tbl.push_back(mk(1, 0, 3, 0, 1, 3, 1, 0, 0,   1, 1, 0, 0)); // load-use on rs2
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0)); // costs exactly one cycle
        tbl.push_back(mk(1, 5, 3, 1, 0, 3, 1, 0, 0,   0, 0, 1, 0)); // rs2 matches but unused
        tbl.push_back(mk(1, 7, 2, 1, 1, 7, 1, 0, 0,   1, 1, 0, 0)); // load-use on rs1
        tbl.push_back(mk(1, 7, 2, 1, 1, 7, 0, 0, 0,   0, 0, 1, 0)); // match but not a load
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0,   0, 1, 1, 0)); // taken branch
        tbl.push_back(mk(1, 3, 3, 1, 1, 3, 1, 1, 1,   0, 1, 1, 1)); // FLUSH ignores everything
        tbl.push_back(mk(1, 3, 3, 1, 1, 3, 1, 1, 1,   0, 1, 1, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0)); // back in RUN
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1,   1, 0, 0, 0)); // busy enters MEM_WAIT
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1,   1, 0, 0, 2)); // branch ignored in wait
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1,   1, 0, 0, 2));
        tbl.push_back(mk(1, 4, 4, 1, 1, 4, 1, 1, 0,   0, 0, 1, 2)); // exit cycle ignores lu/branch
        tbl.push_back(mk(1, 0, 3, 0, 1, 3, 1, 0, 0,   1, 1, 0, 0)); // lu re-evaluated in RUN
        tbl.push_back(mk(1, 3, 3, 1, 1, 3, 1, 1, 1,   0, 1, 1, 0)); // branch+busy+lu: branch wins
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1,   0, 1, 1, 1)); // busy ignored in FLUSH
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1,   1, 0, 0, 0)); // busy re-evaluated in RUN
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 2)); // exit cycle
        tbl.push_back(mk(1, 2, 2, 1, 1, 2, 1, 0, 1,   1, 0, 0, 0)); // busy+lu: MEM_WAIT
        tbl.push_back(mk(1, 2, 2, 1, 1, 2, 1, 0, 1,   1, 0, 0, 2));
        tbl.push_back(mk(0, 2, 2, 1, 1, 2, 1, 1, 1,   0, 1, 0, 2)); // reset mid-MEM_WAIT
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0)); // RUN after release

        reset_in();
        next_edge();
        next_edge();
        for (int i = 0; i < 2; i++) begin
            m_flush_left[i] = 0; m_wait[i] = 0; m_stalls[i] = 0; m_flushes[i] = 0;
        end

        foreach (tbl[k]) begin
            set_in(tbl[k].rn, tbl[k].rs1, tbl[k].rs2, tbl[k].u1, tbl[k].u2, tbl[k].rd,
                   tbl[k].ld, tbl[k].br, tbl[k].busy);
            eval_cycle();
            chk($sformatf("vec%0d.stall", k), int'(d_stall), int'(tbl[k].es));
            chk($sformatf("vec%0d.flush", k), int'(d_flush), int'(tbl[k].ef));
            chk($sformatf("vec%0d.pc_en", k), int'(d_pc_en), int'(tbl[k].ep));
            chk($sformatf("vec%0d.state", k), int'(d_state), int'(tbl[k].est));
            next_edge();
        end
        eval_cycle();
        chk("post_reset.stall_cycles", int'(d_stall_cycles), 0);
        chk("post_reset.flush_events", int'(d_flush_events), 0);
        next_edge();

        // Load-use alone adds one stall cycle.
        reset_in(); cycle();
        set_in(1'b1, 4'd0, 4'd3, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0); cycle();
        nop(); eval_cycle();
        chk("lu.stall_cycles", int'(d_stall_cycles), 1);
        next_edge();

        // Taken branch with penalty 3: three flush cycles, one flush event.
        reset_in(); cycle();
        nflush = 0;
        set_in(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        eval_cycle(); nflush += int'(d_flush); next_edge();
        nop();
        for (int k = 0; k < 3; k++) begin
            eval_cycle(); nflush += int'(d_flush); next_edge();
        end
        chk("branch.flush_cycles", nflush, 3);
        eval_cycle();
        chk("branch.flush_events", int'(d_flush_events), 1);
        next_edge();

        // Four busy cycles: four stalls, then one exit cycle.
        reset_in(); cycle();
        nstall = 0;
        busy_in();
        for (int k = 0; k < 4; k++) begin
            eval_cycle(); nstall += int'(d_stall); next_edge();
        end
        nop();
        eval_cycle();
        chk("memwait.exit_pc_en", int'(d_pc_en), 1);
        chk("memwait.exit_state", int'(d_state), 2);
        next_edge();
        eval_cycle();
        chk("memwait.stall_seen", nstall, 4);
        chk("memwait.stall_cycles", int'(d_stall_cycles), 4);
        chk("memwait.state_after", int'(d_state), 0);
        next_edge();

        // Saturation on the 4-bit instance: 14 = all-ones minus one, then five more.
        reset_in(); cycle();
        busy_in();
        for (int k = 0; k < 19; k++) begin
            eval_cycle();
            if (k == 14) chk("sat.preload", int'(s_stall_cycles), 14);
            next_edge();
        end
        nop(); eval_cycle();
        chk("sat.saturated", int'(s_stall_cycles), 15);
        next_edge();

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            set_in(($urandom_range(0, 59) != 0),
                   4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
